// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory arbiter: FSM states, owner, access sizes
// and the data-side size/alignment check.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // Bytes never fault; the reserved size always does.
    function automatic logic d_cmd_err(input logic [1:0] size, input logic [1:0] addr_lo);
        logic err;
        case (size)
            SZ_WORD: err = (addr_lo != 2'b00);
            SZ_HALF: err = addr_lo[0];
            SZ_BYTE: err = 1'b0;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection. ARB_RR_EN selects round-robin on ties; otherwise
// D wins ties unless the starvation counter has reached STARVE_LIMIT.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       req_i,
    input  logic       req_d,
    input  owner_t     last_grant,
    input  logic [3:0] starve_cnt,
    output logic       grant_valid,
    output owner_t     grant
);

    logic unused_ok;

    assign grant_valid = req_i | req_d;

`ifdef ARB_RR_EN
    assign unused_ok = ^starve_cnt;

    always_comb begin
        grant = OWN_I;
        if (req_i && req_d) begin
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            grant = OWN_D;
        end
    end
`else
    assign unused_ok = logic'(last_grant);

    always_comb begin
        grant = OWN_I;
        if (req_i && req_d) begin
            grant = (starve_cnt >= 4'(STARVE_LIMIT)) ? OWN_I : OWN_D;
        end else if (req_d) begin
            grant = OWN_D;
        end
    end
`endif

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and load/store.
// Build option: define ARB_RR_EN for round-robin tie-breaking instead of D priority.
module unified_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_ena,
    output logic        mem_wena,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Handshake: a requester raises req with its command stable and holds it until
    // the single-cycle ack; ack (with err/rdata) arrives two cycles after acceptance,
    // and the requester drops req in the cycle after ack.

    logic [1:0]  state;
    owner_t      owner;
    owner_t      last_grant;
    logic        err_q;
    logic        we_q;
    logic [3:0]  starve_cnt;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic        in_resp;
    logic        arb_req_i;
    logic        arb_req_d;
    logic        grant_valid;
    owner_t      grant;
    logic        take;

    assign in_resp = (state == ST_RESP);

    // The finishing owner cannot re-win at its own RESP edge.
    assign arb_req_i = i_req & ~(in_resp && owner == OWN_I);
    assign arb_req_d = d_req & ~(in_resp && owner == OWN_D);

    mem_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .req_i      (arb_req_i),
        .req_d      (arb_req_d),
        .last_grant (last_grant),
        .starve_cnt (starve_cnt),
        .grant_valid(grant_valid),
        .grant      (grant)
    );

    assign take = grant_valid && (state == ST_IDLE || state == ST_RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  state <= take ? ST_ISSUE : ST_IDLE;
                ST_ISSUE: state <= ST_RESP;
                ST_RESP:  state <= take ? ST_ISSUE : ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner      <= OWN_I;
            last_grant <= OWN_I;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            size_q     <= SZ_WORD;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
        end else if (take) begin
            owner      <= grant;
            last_grant <= grant;
            if (grant == OWN_I) begin
                err_q  <= (i_addr[1:0] != 2'b00);
                we_q   <= 1'b0;
                size_q <= SZ_WORD;
                addr_q <= i_addr;
            end else begin
                err_q   <= d_cmd_err(d_size, d_addr[1:0]);
                we_q    <= d_we;
                size_q  <= d_size;
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
            end
        end
    end

    // Counts D grants that leave a pending fetch waiting; saturates rather than wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (take) begin
            if (grant == OWN_I) begin
                starve_cnt <= 4'd0;
            end else if (i_req && starve_cnt != 4'hF) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

    assign mem_ena   = (state == ST_ISSUE) && !err_q;
    assign mem_wena  = mem_ena && we_q;
    assign mem_size  = size_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign i_ack   = in_resp && (owner == OWN_I);
    assign d_ack   = in_resp && (owner == OWN_D);
    assign i_err   = i_ack && err_q;
    assign d_err   = d_ack && err_q;
    assign i_rdata = (i_ack && !err_q) ? mem_rdata : 32'd0;
    assign d_rdata = (d_ack && !err_q && !we_q) ? mem_rdata : 32'd0;

    assign busy      = (state == ST_ISSUE) || in_resp;
    assign state_dbg = state;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a table of single accesses plus hand-written
// sequences for reset, ties, starvation forcing and reset during ISSUE.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        mem_ena;
    logic        mem_wena;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [1:0]  state_dbg;

    int n_total = 0;
    int n_pass  = 0;

    unified_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_ena(mem_ena), .mem_wena(mem_wena), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive_idle();
        i_req   = 1'b0;
        i_addr  = 32'd0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_size  = 2'b00;
        d_addr  = 32'd0;
        d_wdata = 32'd0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        we;
        logic [1:0]  size;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        logic        exp_err;
        logic        exp_ena;
        logic        exp_wena;
        logic        chk_cmd;
        logic [1:0]  exp_size;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input int k);
        vec_t v;
        v = vecs[k];
        @(negedge clk);
        mem_rdata = v.rdata_in;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_issue_ena", k), 32'(mem_ena), 32'(v.exp_ena));
        chk($sformatf("v%0d_issue_wena", k), 32'(mem_wena), 32'(v.exp_wena));
        chk($sformatf("v%0d_issue_busy", k), 32'(busy), 32'd1);
        if (v.chk_cmd) begin
            chk($sformatf("v%0d_size", k), 32'(mem_size), 32'(v.exp_size));
            chk($sformatf("v%0d_addr", k), mem_addr, v.addr);
            if (v.exp_wena) chk($sformatf("v%0d_wdata", k), mem_wdata, v.wdata);
        end
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_resp_ena", k), 32'(mem_ena), 32'd0);
        if (v.is_d) begin
            chk($sformatf("v%0d_d_ack", k), 32'(d_ack), 32'd1);
            chk($sformatf("v%0d_d_err", k), 32'(d_err), 32'(v.exp_err));
            chk($sformatf("v%0d_d_rdata", k), d_rdata, v.exp_rdata);
            chk($sformatf("v%0d_i_ack", k), 32'(i_ack), 32'd0);
        end else begin
            chk($sformatf("v%0d_i_ack", k), 32'(i_ack), 32'd1);
            chk($sformatf("v%0d_i_err", k), 32'(i_err), 32'(v.exp_err));
            chk($sformatf("v%0d_i_rdata", k), i_rdata, v.exp_rdata);
            chk($sformatf("v%0d_d_ack", k), 32'(d_ack), 32'd0);
        end
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_idle_busy", k), 32'(busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d_cnt;
        int exp_d_cnt;
        logic i_seen;
        logic d_after;

        //            is_d addr          we    size   wdata          rdata_in       err  ena  wena chk  esize  exp_rdata
        vecs[0] = '{1'b0, 32'h0000_0100, 1'b0, 2'b00, 32'h0,         32'h2402_0005, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h2402_0005};
        vecs[1] = '{1'b1, 32'h0000_0200, 1'b0, 2'b00, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 32'h0000_0013, 1'b1, 2'b10, 32'h0000_00AB, 32'h0000_0055, 1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_0102, 1'b0, 2'b01, 32'h0,         32'h0000_CAFE, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0000_CAFE};
        vecs[4] = '{1'b1, 32'h0000_0040, 1'b1, 2'b00, 32'h1234_5678, 32'h0000_0077, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_0102, 1'b0, 2'b00, 32'h0,         32'h0000_0099, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[6] = '{1'b1, 32'h0000_0101, 1'b1, 2'b01, 32'h0000_5555, 32'h0000_0099, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0000, 1'b0, 2'b11, 32'h0,         32'h0000_0099, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[8] = '{1'b0, 32'h0000_0003, 1'b0, 2'b00, 32'h0,         32'h0000_0099, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0};
        vecs[9] = '{1'b1, 32'h0000_0007, 1'b0, 2'b10, 32'h0,         32'h0000_003C, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0000_003C};

        // Reset held with a fetch pending: everything must read 0.
        drive_idle();
        rst       = 1'b0;
        i_req     = 1'b1;
        i_addr    = 32'h0000_0000;
        mem_rdata = 32'h2402_0005;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_ena",   32'(mem_ena),   32'd0);
        chk("rst_mem_wena",  32'(mem_wena),  32'd0);
        chk("rst_mem_size",  32'(mem_size),  32'd0);
        chk("rst_mem_addr",  mem_addr,       32'd0);
        chk("rst_mem_wdata", mem_wdata,      32'd0);
        chk("rst_i_ack",     32'(i_ack),     32'd0);
        chk("rst_d_ack",     32'(d_ack),     32'd0);
        chk("rst_i_rdata",   i_rdata,        32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_c1_ena",  32'(mem_ena), 32'd1);
        chk("rel_c1_iack", 32'(i_ack),   32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rel_c2_iack",   32'(i_ack), 32'd1);
        chk("rel_c2_ierr",   32'(i_err), 32'd0);
        chk("rel_c2_irdata", i_rdata,    32'h2402_0005);
        drive_idle();
        @(posedge clk);

        for (int k = 0; k < 10; k++) run_vec(k);

        // Tie from IDLE: D first (ack cycle 2), then I (ack cycle 4).
        @(negedge clk);
        mem_rdata = 32'h0000_0A0A;
        i_req = 1'b1; i_addr = 32'h0000_0010;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0000_0020;
        @(posedge clk);
        @(negedge clk);
        chk("tie_c1_addr", mem_addr, 32'h0000_0020);
        @(posedge clk);
        @(negedge clk);
        chk("tie_c2_dack", 32'(d_ack), 32'd1);
        chk("tie_c2_iack", 32'(i_ack), 32'd0);
        d_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("tie_c3_ena",  32'(mem_ena), 32'd1);
        chk("tie_c3_addr", mem_addr,     32'h0000_0010);
        @(posedge clk);
        @(negedge clk);
        chk("tie_c4_iack",   32'(i_ack), 32'd1);
        chk("tie_c4_dack",   32'(d_ack), 32'd0);
        chk("tie_c4_irdata", i_rdata,    32'h0000_0A0A);
        drive_idle();
        @(posedge clk);

        // Starvation: D held, fetch re-raised at every IDLE tie.
`ifdef ARB_RR_EN
        exp_d_cnt = 1;
`else
        exp_d_cnt = 4;
`endif
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_size = 2'b00; d_addr = 32'h0000_0300;
        i_addr = 32'h0000_0400;
        i_req = 1'b1;
        d_cnt = 0; i_seen = 1'b0; d_after = 1'b0;
        for (int c = 0; c < 80 && !d_after; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) begin
                if (i_seen) d_after = 1'b1;
                else d_cnt++;
            end
            if (i_ack) i_seen = 1'b1;
            i_req = (!i_seen && state_dbg == 2'd0) ? 1'b1 : 1'b0;
        end
        chk("starve_d_acks", 32'(d_cnt),   32'(exp_d_cnt));
        chk("starve_i_ack",  32'(i_seen),  32'd1);
        chk("starve_d_resume", 32'(d_after), 32'd1);
        drive_idle();
        repeat (2) @(posedge clk);

        // Reset during ISSUE abandons the access.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h0000_0013; d_wdata = 32'h0000_00AB;
        @(posedge clk);
        @(negedge clk);
        chk("rsti_pre_ena", 32'(mem_ena), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rsti_ena",   32'(mem_ena),  32'd0);
        chk("rsti_wena",  32'(mem_wena), 32'd0);
        chk("rsti_busy",  32'(busy),     32'd0);
        chk("rsti_addr",  mem_addr,      32'd0);
        chk("rsti_wdata", mem_wdata,     32'd0);
        chk("rsti_size",  32'(mem_size), 32'd0);
        drive_idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rsti_noack_%0d", c), 32'(d_ack), 32'd0);
        end
        rst = 1'b1;
        mem_rdata = 32'h1111_2222;
        i_req = 1'b1; i_addr = 32'h0000_0008;
        @(posedge clk);
        @(negedge clk);
        chk("post_c1_ena",  32'(mem_ena), 32'd1);
        chk("post_c1_addr", mem_addr,     32'h0000_0008);
        @(posedge clk);
        @(negedge clk);
        chk("post_c2_iack",   32'(i_ack), 32'd1);
        chk("post_c2_irdata", i_rdata,    32'h1111_2222);
        drive_idle();
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Shares one synchronous-read data memory port between the CPU's instruction-fetch requester and its load/store requester. Accepts one request at a time, sequences it through a fixed issue/response cycle pair, and checks size and alignment before touching memory. Sits between the controller's IM/DM address paths and a single unified memory, so both ports see a req/ack handshake instead of direct memory wiring.

## Interface
- STARVE_LIMIT, 4: consecutive D grants after which a waiting I request is forced through (fixed-priority build only); range 1..15.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  32  fetch byte address; word access only.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ack; misaligned fetch.
- i_rdata  out  32  fetched word, valid with i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 word, 01 half, 10 byte, 11 reserved.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  valid with d_ack; misaligned or reserved size.
- d_rdata  out  32  load data from memory, valid with d_ack on loads.
- mem_ena  out  1  memory access strobe.
- mem_wena  out  1  memory write enable.
- mem_size  out  2  size code passed to memory.
- mem_addr  out  32  memory byte address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, valid the cycle after mem_ena.
- busy  out  1  high in ISSUE and RESP.

## Operation
- States: IDLE, ISSUE, RESP. Owner register: I or D.
- IDLE: sample requests at each edge. If none, stay. Otherwise pick an owner, latch its command into the mem_* registers and go to ISSUE.
- Error check at acceptance:
  - I: addr[1:0] != 0.
  - D word: addr[1:0] != 0.
  - D half: addr[0] != 0.
  - D reserved size 11.
  - The error flag is latched with the command.
- ISSUE: lasts one cycle.
  - mem_ena = 1 unless the command is in error; then mem_ena = 0 and mem_wena = 0.
  - I commands drive mem_wena = 0 and mem_size = 00.
  - Always go to RESP.
- RESP: lasts one cycle.
  - Owner's ack = 1 and err = latched flag.
  - rdata passes mem_rdata through combinationally; it reads 0 on error or store.
  - The non-owner's ack stays 0.
  - At the RESP edge, arbitrate again with the owner's req masked. Go to ISSUE if the other requester is pending, else to IDLE.
- Requesters deassert req the cycle after ack. If req drops before ack (protocol violation), the access still completes and ack still pulses.
- Arbitration, fixed-priority build:
  - D wins ties.
  - A 4-bit counter counts consecutive D grants made while i_req is pending.
  - When the counter reaches STARVE_LIMIT, I is granted next and the counter clears.
  - Any I grant also clears the counter.
- mem_* outputs hold their last values outside ISSUE, except mem_ena and mem_wena, which are 0.

## Timing
- Reset (rst = 0, asynchronous):
  - state = IDLE; all outputs 0.
  - Counter and last-grant register 0.
  - Any in-flight access is abandoned with no ack.
- Latency: request accepted at edge N → mem_ena high in cycle N+1 → ack in cycle N+2.
- Throughput: one access every 2 cycles while requests are pending (RESP → ISSUE chaining).
- Simultaneous i_req and d_req in IDLE: resolved by the arbitration rule.
- A request arriving during ISSUE or RESP waits for the RESP edge.

## Configuration
- ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the requester opposite to the last grant.
  - Last-grant resets to I, so D wins the first tie.
  - The starvation counter and STARVE_LIMIT are unused.
- ARB_RR_EN undefined: D-priority arbitration with the starvation counter, as in Operation.

## Structure
- Package mem_arb_pkg holds:
  - State encoding (IDLE/ISSUE/RESP) and owner encoding (I/D).
  - Size codes SZ_WORD = 00, SZ_HALF = 01, SZ_BYTE = 10.
- Sub-module mem_arb_pick: combinational grant selection.
  - Inputs: masked requests, last grant, counter.
  - Contains the ARB_RR_EN variants, so the top-level FSM is identical in both builds.

## Test plan
- Reset with i_req held high → all outputs 0. Release at edge 0 → mem_ena in cycle 1; i_ack = 1 in cycle 2 with i_rdata = mem_rdata (0x2402_0005).
- i_req and d_req both high from IDLE, D-priority build → D served first (acks in cycles 2 and 4); with ARB_RR_EN after reset → D first, then I, alternating on sustained ties.
- d_req held continuously with i_req pending, STARVE_LIMIT = 4 → exactly 4 D acks, then an I ack, then D resumes.
- Misaligned inputs → the port's ack in cycle 2 with err = 1, mem_ena never 1:
  - d_size = 00, d_addr = 0x0000_0102.
  - d_size = 01, d_addr = 0x0000_0101.
  - d_size = 11.
  - i_addr = 0x0000_0003.
- Store d_we = 1, d_size = 10, d_addr = 0x13, d_wdata = 0xAB in the ISSUE cycle → mem_ena = mem_wena = 1, mem_size = 10, mem_addr = 0x13, mem_wdata = 0xAB. d_ack in the next cycle with d_rdata = 0.
- rst asserted during ISSUE → outputs 0 immediately, no ack. After release, a fresh request completes normally.
